// File: rtl/mem_write_checker.sv
// mem_write_checker: compares the processor's store stream against a
// programmable list of expected (address, data) stores and reports the
// result as registered status.
//   clk, reset_n                       clock, async active-low reset
//   exp_we/exp_idx/exp_addr/exp_data   expected-list write port (IDLE only)
//   start, clear                       arm checker / return to IDLE
//   memwrite/dataadr/writedata         observed store port
//   busy/done/pass/fail                state flags
//   fail_code/fail_addr/fail_data      failure cause and failing store
//   match_count, cycle_count           progress counters
module mem_write_checker #(
  parameter int unsigned NUM_EXP        = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned STRICT         = 1,
  localparam int unsigned IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              clear,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  match_count,
  output logic [31:0]       cycle_count
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EXP - 1);
  // cycle_count value at which a store-less RUN edge times out
  localparam logic [31:0] TO_LIM = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_ADDR  = 3'd1;
  localparam logic [2:0] CODE_DATA  = 3'd2;
  localparam logic [2:0] CODE_TOUT  = 3'd3;
  localparam logic [2:0] CODE_EXTRA = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  match_d;
  logic [31:0]       cycle_d;
  logic [2:0]        code_d;
  logic [ADDR_W-1:0] faddr_d;
  logic [DATA_W-1:0] fdata_d;

  // Expected list; deliberately not reset
  logic [ADDR_W-1:0] exp_a [DEPTH];
  logic [DATA_W-1:0] exp_d [DEPTH];

  always_ff @(posedge clk) begin
    if (exp_we && state_q == IDLE && 32'(exp_idx) < NUM_EXP) begin
      exp_a[exp_idx] <= exp_addr;
      exp_d[exp_idx] <= exp_data;
    end
  end

  // Next-state and next-status computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    match_d = match_count;
    cycle_d = cycle_count;
    code_d  = fail_code;
    faddr_d = fail_addr;
    fdata_d = fail_data;

    if (clear) begin
      state_d = IDLE;
      ptr_d   = '0;
      match_d = '0;
      cycle_d = '0;
      code_d  = CODE_NONE;
      faddr_d = '0;
      fdata_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          cycle_d = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
          if (memwrite) begin
            if (dataadr == exp_a[ptr_q]) begin
              if (writedata == exp_d[ptr_q]) begin
                ptr_d   = ptr_q + IDX_W'(1);
                match_d = match_count + CNT_W'(1);
                if (ptr_q == LAST_IDX) state_d = PASS;
              end else begin
                state_d = FAIL;
                code_d  = CODE_DATA;
                faddr_d = dataadr;
                fdata_d = writedata;
              end
            end else if (STRICT != 0) begin
              state_d = FAIL;
              code_d  = CODE_ADDR;
              faddr_d = dataadr;
              fdata_d = writedata;
            end
          end else if (TIMEOUT_CYCLES != 0 && cycle_d >= TO_LIM) begin
            // >= so a store occupying the exact limit edge cannot skip the timeout
            state_d = FAIL;
            code_d  = CODE_TOUT;
          end
        end
        default: begin
          if (start) begin
            state_d = RUN;
            ptr_d   = '0;
            match_d = '0;
            cycle_d = '0;
            code_d  = CODE_NONE;
            faddr_d = '0;
            fdata_d = '0;
          end else if (state_q == PASS && STRICT != 0 && memwrite) begin
            state_d = FAIL;
            code_d  = CODE_EXTRA;
            faddr_d = dataadr;
            fdata_d = writedata;
          end
        end
      endcase
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= CODE_NONE;
      fail_addr   <= '0;
      fail_data   <= '0;
      match_count <= '0;
      cycle_count <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      busy        <= (state_d == RUN);
      done        <= (state_d == PASS) || (state_d == FAIL);
      pass        <= (state_d == PASS);
      fail        <= (state_d == FAIL);
      fail_code   <= code_d;
      fail_addr   <= faddr_d;
      fail_data   <= fdata_d;
      match_count <= match_d;
      cycle_count <= cycle_d;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a strict 3-entry instance with timeout 10
// and a lenient 1-entry instance with the timeout disabled.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, dataadr, writedata;
  logic        clear;
  logic        s_we, s_start, s_mw;
  logic        l_we, l_start, l_mw;

  logic        s_busy, s_done, s_pass, s_fail;
  logic [2:0]  s_code;
  logic [31:0] s_faddr, s_fdata, s_cyc;
  logic [1:0]  s_match;
  logic        l_busy, l_done, l_pass, l_fail;
  logic [2:0]  l_code;
  logic [31:0] l_faddr, l_fdata, l_cyc;
  logic [0:0]  l_match;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.NUM_EXP(3), .ADDR_W(32), .DATA_W(32),
                      .TIMEOUT_CYCLES(10), .STRICT(1)) u_s (
    .clk(clk), .reset_n(reset_n),
    .exp_we(s_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(s_start), .clear(clear),
    .memwrite(s_mw), .dataadr(dataadr), .writedata(writedata),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
    .fail_code(s_code), .fail_addr(s_faddr), .fail_data(s_fdata),
    .match_count(s_match), .cycle_count(s_cyc));

  mem_write_checker #(.NUM_EXP(1), .ADDR_W(32), .DATA_W(32),
                      .TIMEOUT_CYCLES(0), .STRICT(0)) u_l (
    .clk(clk), .reset_n(reset_n),
    .exp_we(l_we), .exp_idx(exp_idx[0:0]), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(l_start), .clear(clear),
    .memwrite(l_mw), .dataadr(dataadr), .writedata(writedata),
    .busy(l_busy), .done(l_done), .pass(l_pass), .fail(l_fail),
    .fail_code(l_code), .fail_addr(l_faddr), .fail_data(l_fdata),
    .match_count(l_match), .cycle_count(l_cyc));

  typedef struct {
    bit          st;
    bit          mw;
    int unsigned a;
    int unsigned d;
    bit          busy;
    bit          ps;
    bit          fl;
    int unsigned code;
    int unsigned m;
    int unsigned fa;
    int unsigned fd;
  } vec_t;

  vec_t tbl [14];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic load_s;
    s_we = 1'b1;
    exp_idx = 2'd0; exp_addr = 32'd80; exp_data = 32'd7;  step;
    exp_idx = 2'd1; exp_addr = 32'd84; exp_data = 32'd13; step;
    exp_idx = 2'd2; exp_addr = 32'd88; exp_data = 32'd1;  step;
    s_we = 1'b0;
  endtask

  task automatic arm_s;
    s_start = 1'b1; step; s_start = 1'b0;
  endtask

  task automatic store_s(input logic [31:0] a, input logic [31:0] d);
    s_mw = 1'b1; dataadr = a; writedata = d; step; s_mw = 1'b0;
  endtask

  task automatic store_l(input logic [31:0] a, input logic [31:0] d);
    l_mw = 1'b1; dataadr = a; writedata = d; step; l_mw = 1'b0;
  endtask

  initial begin
    // E = (80,7),(84,13),(88,1)
    //            st mw a   d   busy ps fl code m fa  fd
    tbl[0]  = '{1, 0, 0,  0,  1,   0, 0, 0,   0, 0,  0};
    tbl[1]  = '{0, 1, 80, 7,  1,   0, 0, 0,   1, 0,  0};
    tbl[2]  = '{0, 1, 84, 13, 1,   0, 0, 0,   2, 0,  0};
    tbl[3]  = '{0, 1, 88, 1,  0,   1, 0, 0,   3, 0,  0};
    tbl[4]  = '{0, 0, 0,  0,  0,   1, 0, 0,   3, 0,  0};
    tbl[5]  = '{0, 1, 4,  4,  0,   0, 1, 4,   3, 4,  4};
    tbl[6]  = '{0, 1, 80, 7,  0,   0, 1, 4,   3, 4,  4};
    tbl[7]  = '{1, 1, 84, 12, 1,   0, 0, 0,   0, 0,  0};
    tbl[8]  = '{0, 1, 80, 12, 0,   0, 1, 2,   0, 80, 12};
    tbl[9]  = '{1, 0, 0,  0,  1,   0, 0, 0,   0, 0,  0};
    tbl[10] = '{0, 1, 84, 7,  0,   0, 1, 1,   0, 84, 7};
    tbl[11] = '{1, 0, 0,  0,  1,   0, 0, 0,   0, 0,  0};
    tbl[12] = '{0, 1, 80, 7,  1,   0, 0, 0,   1, 0,  0};
    tbl[13] = '{0, 1, 80, 7,  0,   0, 1, 1,   1, 80, 7};

    reset_n = 1'b0; clear = 1'b0;
    s_we = 1'b0; s_start = 1'b0; s_mw = 1'b0;
    l_we = 1'b0; l_start = 1'b0; l_mw = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0; dataadr = '0; writedata = '0;
    step; step;
    chk("reset busy", 32'(s_busy), 0);
    chk("reset done", 32'(s_done), 0);
    chk("reset pass", 32'(s_pass), 0);
    chk("reset fail", 32'(s_fail), 0);
    chk("reset code", 32'(s_code), 0);
    chk("reset match", 32'(s_match), 0);
    chk("reset cycle", s_cyc, 0);
    chk("reset l_busy", 32'(l_busy), 0);
    reset_n = 1'b1;
    step;

    load_s;
    for (int i = 0; i < 14; i++) begin
      s_start = tbl[i].st; s_mw = tbl[i].mw;
      dataadr = tbl[i].a;  writedata = tbl[i].d;
      step;
      s_start = 1'b0; s_mw = 1'b0;
      chk($sformatf("row%0d busy", i),  32'(s_busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d pass", i),  32'(s_pass), 32'(tbl[i].ps));
      chk($sformatf("row%0d fail", i),  32'(s_fail), 32'(tbl[i].fl));
      chk($sformatf("row%0d done", i),  32'(s_done), 32'(tbl[i].ps | tbl[i].fl));
      chk($sformatf("row%0d code", i),  32'(s_code), tbl[i].code);
      chk($sformatf("row%0d match", i), 32'(s_match), tbl[i].m);
      chk($sformatf("row%0d faddr", i), s_faddr, tbl[i].fa);
      chk($sformatf("row%0d fdata", i), s_fdata, tbl[i].fd);
    end

    // Timeout with no stores: fails on the edge where cycle_count reaches 9
    arm_s;
    chk("tout cycle0", s_cyc, 0);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("tout cycle%0d", k), s_cyc, 32'(k));
      chk($sformatf("tout busy%0d", k), 32'(s_busy), 1);
    end
    step;
    chk("tout fail", 32'(s_fail), 1);
    chk("tout code", 32'(s_code), 3);
    chk("tout cycle", s_cyc, 9);
    chk("tout faddr", s_faddr, 0);
    step; step;
    chk("tout frozen", s_cyc, 9);

    // Final matching store on the timeout edge wins
    arm_s;
    store_s(32'd80, 32'd7);
    store_s(32'd84, 32'd13);
    for (int k = 0; k < 6; k++) step;
    chk("race cycle8", s_cyc, 8);
    store_s(32'd88, 32'd1);
    chk("race pass", 32'(s_pass), 1);
    chk("race code", 32'(s_code), 0);
    chk("race cycle", s_cyc, 9);

    // exp_we during RUN must not alter the list
    arm_s;
    s_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd0; exp_data = 32'd0; step; s_we = 1'b0;
    store_s(32'd80, 32'd7);
    chk("we_run match1", 32'(s_match), 1);
    store_s(32'd84, 32'd13);
    store_s(32'd88, 32'd1);
    chk("we_run pass", 32'(s_pass), 1);

    // clear + start together returns to IDLE
    arm_s;
    store_s(32'd80, 32'd7);
    chk("clr pre match", 32'(s_match), 1);
    clear = 1'b1; s_start = 1'b1; step; clear = 1'b0; s_start = 1'b0;
    chk("clr busy", 32'(s_busy), 0);
    chk("clr done", 32'(s_done), 0);
    chk("clr match", 32'(s_match), 0);
    chk("clr cycle", s_cyc, 0);

    // Lenient single-entry instance: foreign stores ignored, no timeout
    l_we = 1'b1; exp_idx = 2'd0; exp_addr = 32'd84; exp_data = 32'd13; step; l_we = 1'b0;
    l_start = 1'b1; step; l_start = 1'b0;
    store_l(32'd60, 32'd5);
    chk("l ignore busy", 32'(l_busy), 1);
    chk("l ignore match", 32'(l_match), 0);
    store_l(32'd84, 32'd13);
    chk("l pass", 32'(l_pass), 1);
    chk("l done", 32'(l_done), 1);
    chk("l match", 32'(l_match), 1);
    chk("l code", 32'(l_code), 0);
    store_l(32'd4, 32'd4);
    chk("l extra pass", 32'(l_pass), 1);
    chk("l extra fail", 32'(l_fail), 0);
    l_start = 1'b1; step; l_start = 1'b0;
    for (int k = 0; k < 30; k++) step;
    chk("l notimeout busy", 32'(l_busy), 1);
    chk("l notimeout cycle", l_cyc, 30);

    // Asynchronous reset mid-RUN after one match
    arm_s;
    store_s(32'd80, 32'd7);
    chk("rst pre match", 32'(s_match), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst busy", 32'(s_busy), 0);
    chk("rst match", 32'(s_match), 0);
    chk("rst cycle", s_cyc, 0);
    chk("rst l_busy", 32'(l_busy), 0);
    #1 reset_n = 1'b1;
    step;
    chk("rst idle busy", 32'(s_busy), 0);
    chk("rst idle done", 32'(s_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
